// File: rtl/inst_fetch32.sv
// Fetch stage: owns the PC, drives the ROM word address, registers {pc, inst} for decode.
// Optional FETCH_PERF_EN adds perf_fetch/perf_stall counters.
module inst_fetch32 #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          ADDR_W       = 10,
    parameter bit          HALT_ON_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall
`endif
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        load;
    logic        zero_halt;
    logic [31:0] redirect_aligned;

    assign load             = !if_valid || if_ready;
    assign zero_halt        = HALT_ON_ZERO && (imem_inst == 32'h0);
    assign redirect_aligned = {redirect_pc[31:2], 2'b00};
    // The ROM indexes words; upper PC bits beyond the ROM size are ignored.
    assign imem_addr        = {{(32-ADDR_W){1'b0}}, pc[ADDR_W+1:2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            if_valid <= 1'b0;
            if_pc    <= 32'h0;
            if_inst  <= 32'h0;
            halted   <= 1'b0;
        end else begin
            unique case (state)
                BOOT: begin
                    state <= RUN;
                end
                RUN: begin
                    if (redirect_valid) begin
                        pc       <= redirect_aligned;
                        if_valid <= 1'b0;
                    end else if (load && zero_halt) begin
                        if_valid <= 1'b0;
                        state    <= HALT;
                        halted   <= 1'b1;
                    end else if (load) begin
                        if_pc    <= pc;
                        if_inst  <= imem_inst;
                        if_valid <= 1'b1;
                        pc       <= pc + 32'd4;
                    end
                end
                HALT: begin
                    if (redirect_valid) begin
                        pc       <= redirect_aligned;
                        if_valid <= 1'b0;
                        state    <= RUN;
                        halted   <= 1'b0;
                    end else if (if_ready) begin
                        if_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch <= 32'h0;
            perf_stall <= 32'h0;
        end else if (state == RUN) begin
            if (!redirect_valid && load && !zero_halt) begin
                perf_fetch <= perf_fetch + 32'd1;
            end
            if (if_valid && !if_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
